// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: tracks what sits in E/M/W and
// derives stalls, forwarding, regfile bypass, redirect flushes, halt drain and perf counters.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16,
   parameter int DRAIN_CYCLES   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_rs1_used,
   input  logic                      id_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_rd_wr_en,
   input  logic                      id_is_load,
   input  logic                      id_halt,
   input  logic                      ex_redirect,
   output logic                      stall_fd,
   output logic                      bubble_de,
   output logic                      flush_fd,
   output logic                      flush_de,
   output logic [1:0]                fwd_a_sel,
   output logic [1:0]                fwd_b_sel,
   output logic                      id_byp_rs1,
   output logic                      id_byp_rs2,
   output logic                      halted,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   localparam int DCW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                    state;
   logic [DCW-1:0]            drain_cnt;

   logic                      e_valid, e_wr, e_is_load, e_rs1_used, e_rs2_used;
   logic [REG_ADDR_WIDTH-1:0] e_rd, e_rs1, e_rs2;
   logic                      m_valid, m_wr, m_is_load;
   logic [REG_ADDR_WIDTH-1:0] m_rd;
   logic                      w_valid, w_wr;
   logic [REG_ADDR_WIDTH-1:0] w_rd;

   logic                      run;
   logic                      load_use;
   logic                      accept;

   // M wins over W so the youngest producer's value reaches E.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_WIDTH-1:0] rs,
      input logic                      used,
      input logic                      mv,
      input logic                      mwr,
      input logic                      mld,
      input logic [REG_ADDR_WIDTH-1:0] mrd,
      input logic                      wv,
      input logic                      wwr,
      input logic [REG_ADDR_WIDTH-1:0] wrd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (mv && mwr && !mld && (mrd == rs) && used)
         sel = 2'b01;
      else if (wv && wwr && (wrd == rs) && used)
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      run      = (state == ST_RUN);
      load_use = e_valid && e_is_load && e_wr && id_valid && !ex_redirect && run &&
                 ((id_rs1_used && (e_rd == id_rs1)) || (id_rs2_used && (e_rd == id_rs2)));
      stall_fd  = load_use || !run;
      bubble_de = load_use;
      flush_fd  = ex_redirect;
      flush_de  = ex_redirect;
      accept    = id_valid && !stall_fd && !ex_redirect && run;
      fwd_a_sel = fwd_sel(e_rs1, e_rs1_used, m_valid, m_wr, m_is_load, m_rd, w_valid, w_wr, w_rd);
      fwd_b_sel = fwd_sel(e_rs2, e_rs2_used, m_valid, m_wr, m_is_load, m_rd, w_valid, w_wr, w_rd);
      id_byp_rs1 = w_valid && w_wr && (w_rd == id_rs1) && id_rs1_used && id_valid;
      id_byp_rs2 = w_valid && w_wr && (w_rd == id_rs2) && id_rs2_used && id_valid;
   end

   // Shadow of E/M/W; x0 is never a real destination, so its write enable is dropped here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         e_valid    <= 1'b0;
         e_wr       <= 1'b0;
         e_is_load  <= 1'b0;
         e_rd       <= '0;
         e_rs1      <= '0;
         e_rs1_used <= 1'b0;
         e_rs2      <= '0;
         e_rs2_used <= 1'b0;
         m_valid    <= 1'b0;
         m_wr       <= 1'b0;
         m_is_load  <= 1'b0;
         m_rd       <= '0;
         w_valid    <= 1'b0;
         w_wr       <= 1'b0;
         w_rd       <= '0;
      end else begin
         m_valid   <= e_valid;
         m_wr      <= e_wr;
         m_is_load <= e_is_load;
         m_rd      <= e_rd;
         w_valid   <= m_valid;
         w_wr      <= m_wr;
         w_rd      <= m_rd;
         if (accept) begin
            e_valid    <= 1'b1;
            e_wr       <= id_rd_wr_en && (id_rd != '0);
            e_is_load  <= id_is_load;
            e_rd       <= id_rd;
            e_rs1      <= id_rs1;
            e_rs1_used <= id_rs1_used;
            e_rs2      <= id_rs2;
            e_rs2_used <= id_rs2_used;
         end else begin
            e_valid    <= 1'b0;
            e_wr       <= 1'b0;
            e_is_load  <= 1'b0;
            e_rd       <= '0;
            e_rs1      <= '0;
            e_rs1_used <= 1'b0;
            e_rs2      <= '0;
            e_rs2_used <= 1'b0;
         end
      end
   end

   // HALTED is entered on the edge where the drain counter would reach zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept && id_halt) begin
                  if (DRAIN_CYCLES <= 1) begin
                     state  <= ST_HALTED;
                     halted <= 1'b1;
                  end else begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt <= DCW'(1)) begin
                  state     <= ST_HALTED;
                  halted    <= 1'b1;
                  drain_cnt <= '0;
               end else begin
                  drain_cnt <= drain_cnt - DCW'(1);
               end
            end
            ST_HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               state     <= ST_RUN;
               drain_cnt <= '0;
               halted    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (load_use && (stall_count != {CNT_WIDTH{1'b1}}))
            stall_count <= stall_count + CNT_WIDTH'(1);
         if (ex_redirect && (flush_count != {CNT_WIDTH{1'b1}}))
            flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all checked against
// an instruction-level model of what occupies E, M and W.
module tb_pipe_hazard_ctrl;

   localparam int AW    = 5;
   localparam int CW    = 16;
   localparam int DRAIN = 3;

   logic          clk;
   logic          rst;
   logic          d_valid;
   logic [AW-1:0] d_rs1, d_rs2, d_rd;
   logic          d_u1, d_u2, d_wr, d_ld, d_halt, redir;
   logic          stall_fd, bubble_de, flush_fd, flush_de;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          id_byp_rs1, id_byp_rs2, halted;
   logic [CW-1:0] stall_count, flush_count;

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst),
      .id_valid(d_valid), .id_rs1(d_rs1), .id_rs2(d_rs2),
      .id_rs1_used(d_u1), .id_rs2_used(d_u2),
      .id_rd(d_rd), .id_rd_wr_en(d_wr), .id_is_load(d_ld), .id_halt(d_halt),
      .ex_redirect(redir),
      .stall_fd(stall_fd), .bubble_de(bubble_de), .flush_fd(flush_fd), .flush_de(flush_de),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
      .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      bit          v;
      bit [AW-1:0] rd;
      bit          wr;
      bit          ld;
      bit [AW-1:0] rs1;
      bit          u1;
      bit [AW-1:0] rs2;
      bit          u2;
   } ins_t;

   ins_t me, mm, mw;
   int   age;          // -1 running, else cycles since halt acceptance
   int   scnt, fcnt;
   bit   known;
   bit   x_hazard, x_stall, x_accept, x_halted, x_b1, x_b2;
   bit [1:0] x_fa, x_fb;
   int   compared, mismatched;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [1:0] fwd_exp(input bit [AW-1:0] rs, input bit used);
      if (mm.v && mm.wr && !mm.ld && mm.rd == rs && used) return 2'b01;
      if (mw.v && mw.wr && mw.rd == rs && used) return 2'b10;
      return 2'b00;
   endfunction

   function automatic void eval_model();
      bit run;
      run      = (age < 0);
      x_hazard = run && d_valid && !redir && me.v && me.ld && me.wr &&
                 ((d_u1 && me.rd == d_rs1) || (d_u2 && me.rd == d_rs2));
      x_stall  = x_hazard || !run;
      x_accept = d_valid && !x_stall && !redir && run;
      x_halted = (age >= DRAIN);
      x_fa     = fwd_exp(me.rs1, me.u1);
      x_fb     = fwd_exp(me.rs2, me.u2);
      x_b1     = mw.v && mw.wr && mw.rd == d_rs1 && d_u1 && d_valid;
      x_b2     = mw.v && mw.wr && mw.rd == d_rs2 && d_u2 && d_valid;
   endfunction

   task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wr, input bit ld, input bit hlt, input bit rdr);
      d_valid = v;
      d_rs1   = AW'(rs1);
      d_u1    = u1;
      d_rs2   = AW'(rs2);
      d_u2    = u2;
      d_rd    = AW'(rd);
      d_wr    = wr;
      d_ld    = ld;
      d_halt  = hlt;
      redir   = rdr;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check();
      #2;
      eval_model();
      if (known) begin
         chk("stall_fd", stall_fd, x_stall);
         chk("bubble_de", bubble_de, x_hazard);
         chk("flush_fd", flush_fd, redir);
         chk("flush_de", flush_de, redir);
         chk("fwd_a_sel", fwd_a_sel, x_fa);
         chk("fwd_b_sel", fwd_b_sel, x_fb);
         chk("id_byp_rs1", id_byp_rs1, x_b1);
         chk("id_byp_rs2", id_byp_rs2, x_b2);
         chk("halted", halted, x_halted);
         chk("stall_count", stall_count, scnt);
         chk("flush_count", flush_count, fcnt);
         chk("no_load_in_m_feeding_e",
             mm.v && mm.ld && mm.wr && me.v &&
             ((me.u1 && me.rs1 == mm.rd) || (me.u2 && me.rs2 == mm.rd)), 0);
         chk("no_redirect_while_draining", redir && rst && age > 0, 0);
      end
   endtask

   task automatic tick();
      ins_t cap;
      eval_model();
      @(posedge clk);
      if (!rst) begin
         me = '0; mm = '0; mw = '0;
         age = -1; scnt = 0; fcnt = 0;
         known = 1'b1;
      end else begin
         cap = '0;
         if (x_accept) begin
            cap.v = 1; cap.rd = d_rd; cap.wr = d_wr && (d_rd != 0); cap.ld = d_ld;
            cap.rs1 = d_rs1; cap.u1 = d_u1; cap.rs2 = d_rs2; cap.u2 = d_u2;
         end
         mw = mm;
         mm = me;
         me = cap;
         if (x_hazard && scnt < 65535) scnt++;
         if (redir && fcnt < 65535) fcnt++;
         if (age > 0) begin
            if (age < 1000) age++;
         end else if (x_accept && d_halt) begin
            age = 1;
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc();
      check();
      tick();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      nop();
      for (int i = 0; i < n; i++) cyc();
      rst = 1'b1;
   endtask

   initial begin
      compared = 0; mismatched = 0;
      known = 1'b0; age = -1; scnt = 0; fcnt = 0;
      me = '0; mm = '0; mw = '0;
      rst = 1'b0;
      nop();

      // reset state
      do_reset(2);
      nop(); check();
      chk("rst_stall", stall_fd, 0); chk("rst_fwd_a", fwd_a_sel, 0); chk("rst_fwd_b", fwd_b_sel, 0);
      chk("rst_halted", halted, 0); chk("rst_scnt", stall_count, 0); chk("rst_fcnt", flush_count, 0);
      tick();

      // M forwarding: add x5 then sub x6,x5,x1
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc();
      drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); cyc();
      nop(); check(); chk("fwd_from_m", fwd_a_sel, 2'b01); tick();
      // W forwarding: two apart
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc();
      nop(); cyc();
      drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); cyc();
      nop(); check(); chk("fwd_from_w", fwd_a_sel, 2'b10); tick();
      // W->D bypass
      drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0); cyc();
      nop(); cyc(); nop(); cyc();
      drive(1, 5, 1, 3, 1, 9, 1, 0, 0, 0); check(); chk("byp_rs1", id_byp_rs1, 1); tick();

      // load-use
      do_reset(1);
      drive(1, 2, 1, 0, 0, 7, 1, 1, 0, 0); cyc();
      drive(1, 7, 1, 7, 1, 8, 1, 0, 0, 0); check();
      chk("lu_stall", stall_fd, 1); chk("lu_bubble", bubble_de, 1); tick();
      check(); chk("lu_stall_once", stall_fd, 0); tick();
      nop(); check();
      chk("lu_fwd_a", fwd_a_sel, 2'b10); chk("lu_fwd_b", fwd_b_sel, 2'b10);
      chk("lu_scnt", stall_count, 1); tick();

      // redirect over a load-use hazard
      drive(1, 2, 1, 0, 0, 7, 1, 1, 0, 0); cyc();
      drive(1, 7, 1, 7, 1, 8, 1, 0, 0, 1); check();
      chk("rd_flush_fd", flush_fd, 1); chk("rd_flush_de", flush_de, 1);
      chk("rd_stall", stall_fd, 0); chk("rd_bubble", bubble_de, 0); tick();
      nop(); check(); chk("rd_fcnt", flush_count, 1); chk("rd_scnt", stall_count, 1); tick();

      // halt drain
      do_reset(1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); check(); chk("halt_accept", stall_fd, 0); tick();
      for (int k = 1; k <= 5; k++) begin
         nop(); check();
         chk("halt_stall", stall_fd, 1);
         chk("halt_timing", halted, (k >= 3) ? 1 : 0);
         tick();
      end
      do_reset(1);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); check(); chk("halt_flushed", flush_fd, 1); tick();
      for (int k = 1; k <= 4; k++) begin
         nop(); check(); chk("halt_not_taken", stall_fd, 0); chk("halt_not_halted", halted, 0); tick();
      end

      // x0 writes never forward, stall or bypass
      do_reset(1);
      drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 0); cyc();
      drive(1, 2, 1, 0, 0, 0, 1, 1, 0, 0); cyc();
      drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0); check(); chk("x0_no_stall", stall_fd, 0); tick();
      drive(1, 0, 1, 0, 1, 10, 1, 0, 0, 0); check();
      chk("x0_fwd_a", fwd_a_sel, 0); chk("x0_fwd_b", fwd_b_sel, 0); chk("x0_byp", id_byp_rs1, 0);
      tick();

      // flush counter saturation
      do_reset(1);
      for (int i = 0; i < 65540; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 7), 1, $urandom_range(0, 7), 1,
               $urandom_range(0, 7), 1, $urandom_range(0, 1), 0, 1);
         cyc();
      end
      nop(); check(); chk("fcnt_sat", flush_count, 16'hFFFF); tick();

      // random traffic
      do_reset(1);
      for (int i = 0; i < 3000; i++) begin
         if (age >= DRAIN + 3) begin
            do_reset(1);
         end else begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0,
                  (age < 0) && ($urandom_range(0, 9) == 0));
            cyc();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Centralised hazard and pipeline-control block for the 5-stage (F/D/E/M/W) RISC-V core. It replaces the free-running "always advance, flush on branch" scheme.
- Keeps its own shadow record of the instructions in E, M and W. From that record it generates:
  - load-use stalls,
  - E-stage operand forwarding selects,
  - the W→D regfile bypass,
  - redirect flushes,
  - an orderly halt-drain sequence.
- Also exports saturating stall and flush performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register-address width.
- CNT_WIDTH, 16, width of each performance counter.
- DRAIN_CYCLES, 3, cycles after halt acceptance until halt leaves W (E, M, W).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous active-low (asserted when 0, sampled on posedge clk)
- id_valid  in  1  D stage holds a real instruction
- id_rs1  in  REG_ADDR_WIDTH  D-stage source 1
- id_rs2  in  REG_ADDR_WIDTH  D-stage source 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_WIDTH  D-stage destination
- id_rd_wr_en  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_halt  in  1  instruction is halt
- ex_redirect  in  1  branch taken or jump in E
- stall_fd  out  1  hold PC and IF/ID
- bubble_de  out  1  load NOP controls into ID/EX
- flush_fd  out  1  replace IF/ID instruction with NOP
- flush_de  out  1  clear ID/EX controls
- fwd_a_sel  out  2  E operand A: 00 regfile, 01 M result, 10 W result
- fwd_b_sel  out  2  E operand B, same encoding as fwd_a_sel
- id_byp_rs1  out  1  D rs1 must take RD_DATA (W write this cycle)
- id_byp_rs2  out  1  D rs2 must take RD_DATA (W write this cycle)
- halted  out  1  pipeline fully drained after halt
- stall_count  out  CNT_WIDTH  load-use stall cycles, saturating
- flush_count  out  CNT_WIDTH  redirect events, saturating

Behaviour:
- **Reset** (rst=0 at posedge):
  - all shadow slots invalid, FSM in RUN, counters 0, halted 0.
  - Combinational outputs then evaluate to 0 / 00, because every slot is invalid.
- **Shadow slots:**
  - E holds {valid, rd, wr, is_load, rs1, rs1_used, rs2, rs2_used}.
  - M and W hold {valid, rd, wr, is_load}.
  - rd=0 forces wr=0 on capture.
  - Every cycle: M←E and W←M.
  - E←D fields only when D is accepted: id_valid && !stall_fd && !ex_redirect && state==RUN. Otherwise E←invalid bubble.
- **Load-use stall** (combinational): stall_fd = bubble_de = 1 when all of the following hold:
  - E.valid, E.is_load, E.wr,
  - E.rd matches a used id_rs,
  - id_valid,
  - !ex_redirect,
  - state==RUN.
  - Duration is exactly 1 cycle per hazard.
- **Redirect** (ex_redirect=1) has priority over stall:
  - flush_fd = flush_de = 1, stall_fd = 0, bubble_de = 0.
  - flush_count +1 (saturates at all-ones).
- **Forwarding** (from E, M, W state), per operand:
  - 01 if M.valid && M.wr && !M.is_load && M.rd==E.rs && E.rs_used;
  - else 10 if W.valid && W.wr && W.rd==E.rs && E.rs_used;
  - else 00.
  - M has priority over W.
  - A load in M matching E is impossible by construction; the bench asserts it.
- **W→D bypass:** id_byp_rsN = W.valid && W.wr && W.rd==id_rsN && id_rsN_used && id_valid.
- **Halt FSM** (RUN → DRAIN → HALTED):
  - RUN→DRAIN when D is accepted with id_halt=1. A halt in D that is flushed by ex_redirect is not accepted.
  - DRAIN: stall_fd = 1; E receives bubbles; down-counter loaded with DRAIN_CYCLES-1 at entry, decremented each cycle.
  - DRAIN→HALTED when the counter reaches 0 (i.e. DRAIN_CYCLES cycles after acceptance). halted = 1 from then on.
  - HALTED: stall_fd = 1 and halted = 1, sticky until reset.
  - Reset in any state returns to RUN next cycle.
  - ex_redirect cannot occur in DRAIN, because only older instructions remain; the bench asserts this.
- **stall_count:** +1 each load-use stall cycle; saturates; does not count DRAIN/HALTED stalls.

Test Plan:
- Reset with rst=0 for 2 cycles → all outputs 0, fwd selects 00, counters 0.
- Back-to-back dependency: add x5 (E) then sub x6,x5,x1 (D) → next cycle fwd_a_sel=01. Two cycles apart → 10. Same-cycle W write of x5 with x5 read in D → id_byp_rs1=1.
- Load-use: lw x7 in E, add x8,x7,x7 in D → stall_fd=bubble_de=1 for exactly 1 cycle; then fwd_a_sel=fwd_b_sel=10; stall_count=1.
- Redirect concurrent with a load-use hazard → flush_fd=flush_de=1, stall_fd=0, flush_count=1, stall_count unchanged.
- Halt in D accepted → halted rises exactly 3 cycles later, stall_fd=1 throughout. A halt in D flushed by ex_redirect → FSM stays RUN.
- Writes to x0 in M/W with a dependent x0 read → fwd selects 00, no stall. Run 65540 redirects → flush_count saturates at 0xFFFF.
